// File: rtl/code_bus_arbiter_pkg.sv
// Shared types for the code-memory bus arbiter: owner tags for the returning read slot.
// Also provides the starvation-counter width helper.
package code_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_FETCH  = 2'd1,
        OWN_EXT_RD = 2'd2
    } owner_t;

    function automatic int starve_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/code_bus_arbiter.sv
// Shares the single-port code memory between instruction fetch (default owner) and an external port.
// Latency: grant/mux combinational, read data returns 1 cycle after the address cycle.
// Backpressure: ext_req waits on ext_gnt; fetch is stalled on every ext grant, forced through after STARVE_LIMIT.
module code_bus_arbiter
    import code_bus_arbiter_pkg::*;
#(
    parameter int ADDR_SIZE    = 18,
    parameter int WORD_SIZE    = 18,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [ADDR_SIZE-1:0] fetch_addr,
    output logic                 fetch_stall,
    output logic [WORD_SIZE-1:0] fetch_data,
    output logic                 fetch_valid,
    input  logic                 ext_req,
    input  logic                 ext_we,
    input  logic [ADDR_SIZE-1:0] ext_addr,
    input  logic [WORD_SIZE-1:0] ext_wdata,
    output logic                 ext_gnt,
    output logic [WORD_SIZE-1:0] ext_rdata,
    output logic                 ext_rvalid,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic                 mem_we,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata
);

    localparam int            CW    = starve_width(STARVE_LIMIT);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_cnt;
    logic [CW-1:0] starve_d;
    owner_t        owner_q;
    owner_t        owner_d;
    logic          gnt;

    // Gating with reset keeps a write from reaching memory while reset is held low.
    assign gnt = reset & ext_req & (starve_cnt < LIMIT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
            owner_q    <= OWN_NONE;
        end else begin
            starve_cnt <= starve_d;
            owner_q    <= owner_d;
        end
    end

    // Any fetch-owned cycle clears the count, so fetch gets exactly one slot per starvation event.
    always_comb begin
        starve_d = '0;
        owner_d  = OWN_FETCH;
        if (gnt) begin
            starve_d = starve_cnt + 1'b1;
            owner_d  = ext_we ? OWN_NONE : OWN_EXT_RD;
        end
    end

    always_comb begin
        ext_gnt     = gnt;
        fetch_stall = gnt;
        mem_addr    = gnt ? ext_addr : fetch_addr;
        mem_we      = gnt & ext_we;
        mem_wdata   = gnt ? ext_wdata : '0;
        fetch_valid = (owner_q == OWN_FETCH);
        ext_rvalid  = (owner_q == OWN_EXT_RD);
        fetch_data  = mem_rdata;
        ext_rdata   = mem_rdata;
    end

endmodule
